lvds_tx: RTL and testbench
==========================

Name: lvds_tx

Overview:
- Transmit-side counterpart of the LVDS receive path.
- Pulls 32-bit complex I/Q words from the TX complex FIFO and frames them in the modem I/Q format (I sync, I data, Q sync, Q data).
- Serializes each word MSB-first as 16 bit-pairs, one pair per clock, into the DDR output SB_IO that drives o_iq_tx_p/n.
- Back-to-back words stream gaplessly; FIFO underruns are detected and counted.

Parameters:
- FORCE_SYNC, 1: when 1, bits 31:30 are overwritten with 2'b10 and bits 15:14 with 2'b01; when 0, the word is sent unmodified.
- UNDERRUN_CNT_W, 16: width of the saturating underrun counter.

Ports:
- i_ddr_clk  in  1: TX LVDS clock, the only clock.
- i_reset  in  1: synchronous, active-high reset.
- i_enable  in  1: streaming enable.
- i_fifo_empty  in  1: TX FIFO empty flag.
- o_fifo_pull  out  1: FIFO read enable; data is valid on i_fifo_data the cycle after.
- i_fifo_data  in  32: FIFO read data. I = [29:17], I ctrl = [16], Q = [13:1], Q ctrl = [0].
- o_ddr_data  out  2: {d1, d0} to SB_IO D_OUT_1/D_OUT_0. d0 (rising edge) carries the earlier bit.
- o_tx_active  out  1: high while a frame is being shifted.
- o_underrun  out  1: one-cycle pulse on underrun.
- o_underrun_count  out  UNDERRUN_CNT_W: saturating count of underruns.

Behaviour:
- Reset values: o_fifo_pull=0, o_ddr_data=2'b00, o_tx_active=0, o_underrun=0, o_underrun_count=0, state=IDLE, pair_cnt=0.
- Reset mid-frame: takes effect in the next cycle. The frame is abandoned, the output returns to 00 and no pull is issued.
- All outputs are registered.
- State IDLE:
  - o_ddr_data=00.
  - If i_enable & !i_fifo_empty, go to FETCH.
- State FETCH: o_fifo_pull=1 for exactly this one cycle; go to LOAD.
- State LOAD:
  - Capture framed(i_fifo_data) into shift register sr[31:0].
  - Go to TX with pair_cnt=0.
- State TX:
  - o_ddr_data = {sr[31-2k-1], sr[31-2k]} for pair_cnt=k (k=0..15). d0=sr[31-2k], d1=sr[30-2k].
  - o_tx_active=1.
  - pair_cnt increments every cycle and wraps 15->0.
- Prefetch:
  - In the cycle with pair_cnt==13, sample i_enable and i_fifo_empty.
  - If enable & !empty: o_fifo_pull=1 during pair_cnt==14.
  - The word arrives during pair_cnt==15 and is loaded into sr at the end of that cycle.
  - The next frame starts at pair_cnt=0 with no gap. Sustained rate is one word per 16 clocks.
- End of frame, no word prefetched:
  - Return to IDLE after pair_cnt==15; o_ddr_data=00 from the next cycle.
  - If i_enable was 1 at the pair_cnt==13 sample (FIFO empty): underrun. o_underrun pulses in the first IDLE cycle and o_underrun_count increments, saturating at all-ones.
  - If i_enable was 0: clean stop, no underrun.
- Enable timing:
  - i_enable deassertion never truncates a frame in flight.
  - Deassertion after the pair_cnt==13 sample, once a word was pulled, still sends that word.
  - i_enable asserted in IDLE with FIFO empty: stay in IDLE, no underrun counted.
- FIFO flags:
  - o_fifo_pull is never asserted when i_fifo_empty was high at the decision cycle.
  - Fill level is not observed (no full port).
- Latency:
  - Pull (FETCH) at cycle P → first pair on o_ddr_data at P+2 → last pair at P+17.
  - IDLE decision to first pair: 3 cycles.

Test Plan:
- Single word: reset; FIFO holds 32'h0000_0000; FORCE_SYNC=1; i_enable=1 → one-cycle pull, then 16 pairs of 32'h8000_4000. Pair0 o_ddr_data=2'b01, pair8=2'b10, all others 00. Then IDLE 00, o_underrun pulses once, o_underrun_count=1.
- Back-to-back: FIFO holds 32'h3FFF_3FFF and 32'h0001_0001 → pull seen at pair_cnt 14 of frame 1. Frame 2 starts the cycle after pair 15 with no gap. Frame 1 framed=32'hBFFF_7FFF; o_ddr_data=11 on every pair except pair0=01 and pair8=10. Exactly two pulls total.
- Clean stop: drop i_enable at pair_cnt==5 of frame 1 with FIFO non-empty → frame completes, no pull at pair 14, o_underrun stays 0, count unchanged.
- Reset mid-frame: assert i_reset at pair_cnt==7 → next cycle o_ddr_data=00, o_tx_active=0, o_fifo_pull=0, count=0. Release with FIFO non-empty → a fresh FETCH occurs.
- FORCE_SYNC=0: word 32'h1234_5678 → transmitted bit-exact MSB-first. Pair0 {d1,d0}=2'b00 (bits 31,30 = 0,0), pair1=2'b10 (bit 29=0 on d0, bit 28=1 on d1).
- Underrun saturation: UNDERRUN_CNT_W=2; force 5 underruns → count 1,2,3,3,3; o_underrun pulses 5 times.

Source files
------------

// File: rtl/lvds_tx_if.sv
// TX complex FIFO read port seen from the LVDS transmitter.
// Pull strobe goes out; the empty flag and the read word come back (word valid the cycle after a pull).
// No backpressure: the transmitter only pulls when it saw a non-empty FIFO.
//   master : transmitter side (drives o_fifo_pull)
//   slave  : FIFO side (drives i_fifo_empty, i_fifo_data)
interface lvds_tx_if;
    logic        i_fifo_empty;
    logic        o_fifo_pull;
    logic [31:0] i_fifo_data;

    modport master (
        output o_fifo_pull,
        input  i_fifo_empty,
        input  i_fifo_data
    );

    modport slave (
        input  o_fifo_pull,
        output i_fifo_empty,
        output i_fifo_data
    );
endinterface

// File: rtl/lvds_tx.sv
// LVDS I/Q transmitter: frames FIFO words and shifts them MSB-first as 16 DDR bit-pairs per word.
// Latency: pull at P, first pair at P+2, last pair at P+17; IDLE decision to first pair is 3 cycles.
// Backpressure: none downstream; upstream is pulled only when non-empty, an empty FIFO at the prefetch point is an underrun.
//
// Ports:
//   i_ddr_clk          TX LVDS clock (only clock)
//   i_reset            synchronous active-high reset
//   i_enable           streaming enable, sampled at IDLE and at pair 13
//   fifo               FIFO read port (pull / empty / data)
//   o_ddr_data         {d1, d0} to the DDR SB_IO; d0 (rising edge) carries the earlier bit
//   o_tx_active        high while a frame is being shifted
//   o_underrun         one-cycle pulse in the first IDLE cycle after an underrun
//   o_underrun_count   saturating underrun counter
module lvds_tx #(
    parameter int FORCE_SYNC     = 1,
    parameter int UNDERRUN_CNT_W = 16
) (
    input  logic                      i_ddr_clk,
    input  logic                      i_reset,
    input  logic                      i_enable,
    lvds_tx_if.master                 fifo,
    output logic [1:0]                o_ddr_data,
    output logic                      o_tx_active,
    output logic                      o_underrun,
    output logic [UNDERRUN_CNT_W-1:0] o_underrun_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;
    localparam logic [1:0] ST_TX    = 2'd3;

    // Pair index at which the next word is decided; the pull lands on the
    // following pair and the data on the last pair of the frame.
    localparam logic [3:0] PAIR_DECIDE = 4'd13;
    localparam logic [3:0] PAIR_LAST   = 4'd15;

    logic [1:0]                state_q,    state_d;
    logic [3:0]                pair_cnt_q, pair_cnt_d;
    logic [31:0]               sr_q,       sr_d;
    logic                      pf_q,       pf_d;      // a word was pulled for the next frame
    logic                      en13_q,     en13_d;    // enable seen at the decision pair
    logic                      pull_q,     pull_d;
    logic [1:0]                ddr_q,      ddr_d;
    logic                      active_q,   active_d;
    logic                      urun_q,     urun_d;
    logic [UNDERRUN_CNT_W-1:0] cnt_q,      cnt_d;

    logic [31:0]               framed;

    // Modem I/Q framing: I sync in [31:30], Q sync in [15:14].
    always_comb begin
        framed = fifo.i_fifo_data;
        if (FORCE_SYNC != 0) begin
            framed[31:30] = 2'b10;
            framed[15:14] = 2'b01;
        end
    end

    always_comb begin
        state_d    = state_q;
        pair_cnt_d = pair_cnt_q;
        sr_d       = sr_q;
        pf_d       = pf_q;
        en13_d     = en13_q;
        pull_d     = 1'b0;
        ddr_d      = 2'b00;
        urun_d     = 1'b0;
        cnt_d      = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (i_enable && !fifo.i_fifo_empty) begin
                    state_d = ST_FETCH;
                    pull_d  = 1'b1;
                end
            end

            ST_FETCH: begin
                state_d = ST_LOAD;
            end

            // Word is on the FIFO bus now. Pair 0 goes straight to the output
            // register, the remaining 30 bits wait in the shift register.
            ST_LOAD: begin
                ddr_d      = {framed[30], framed[31]};
                sr_d       = {framed[29:0], 2'b00};
                pair_cnt_d = 4'd0;
                pf_d       = 1'b0;
                en13_d     = 1'b0;
                state_d    = ST_TX;
            end

            ST_TX: begin
                pair_cnt_d = pair_cnt_q + 4'd1;

                if (pair_cnt_q == PAIR_DECIDE) begin
                    en13_d = i_enable;
                    pf_d   = i_enable && !fifo.i_fifo_empty;
                    pull_d = i_enable && !fifo.i_fifo_empty;
                end

                if (pair_cnt_q == PAIR_LAST) begin
                    if (pf_q) begin
                        // Prefetched word arrives on the last pair: chain it
                        // in so the next frame follows with no gap.
                        ddr_d  = {framed[30], framed[31]};
                        sr_d   = {framed[29:0], 2'b00};
                        pf_d   = 1'b0;
                        en13_d = 1'b0;
                    end else begin
                        state_d    = ST_IDLE;
                        pair_cnt_d = 4'd0;
                        // Enabled but nothing to send: the FIFO ran dry.
                        if (en13_q) begin
                            urun_d = 1'b1;
                            if (cnt_q != {UNDERRUN_CNT_W{1'b1}}) begin
                                cnt_d = cnt_q + UNDERRUN_CNT_W'(1);
                            end
                        end
                    end
                end else begin
                    ddr_d = {sr_q[30], sr_q[31]};
                    sr_d  = {sr_q[29:0], 2'b00};
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        active_d = (state_d == ST_TX);
    end

    always_ff @(posedge i_ddr_clk) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            pair_cnt_q <= 4'd0;
            sr_q       <= 32'd0;
            pf_q       <= 1'b0;
            en13_q     <= 1'b0;
            pull_q     <= 1'b0;
            ddr_q      <= 2'b00;
            active_q   <= 1'b0;
            urun_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pair_cnt_q <= pair_cnt_d;
            sr_q       <= sr_d;
            pf_q       <= pf_d;
            en13_q     <= en13_d;
            pull_q     <= pull_d;
            ddr_q      <= ddr_d;
            active_q   <= active_d;
            urun_q     <= urun_d;
            cnt_q      <= cnt_d;
        end
    end

    assign fifo.o_fifo_pull = pull_q;
    assign o_ddr_data       = ddr_q;
    assign o_tx_active      = active_q;
    assign o_underrun       = urun_q;
    assign o_underrun_count = cnt_q;

endmodule

// File: tb/tb_lvds_tx.sv
// Bench for lvds_tx: two instances (FORCE_SYNC=1/16-bit count, FORCE_SYNC=0/2-bit count)
// share one FIFO model and stimulus; each has its own expected-frame queue.
module tb_lvds_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        enable;
    logic        fifo_empty;
    logic [31:0] fifo_data;

    lvds_tx_if ifa ();
    lvds_tx_if ifb ();
    assign ifa.i_fifo_empty = fifo_empty;
    assign ifa.i_fifo_data  = fifo_data;
    assign ifb.i_fifo_empty = fifo_empty;
    assign ifb.i_fifo_data  = fifo_data;

    logic [1:0]  ddr_a, ddr_b;
    logic        act_a, act_b, ur_a, ur_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;

    lvds_tx #(.FORCE_SYNC(1), .UNDERRUN_CNT_W(16)) dut_a (
        .i_ddr_clk(clk), .i_reset(rst), .i_enable(enable), .fifo(ifa),
        .o_ddr_data(ddr_a), .o_tx_active(act_a), .o_underrun(ur_a), .o_underrun_count(cnt_a)
    );

    lvds_tx #(.FORCE_SYNC(0), .UNDERRUN_CNT_W(2)) dut_b (
        .i_ddr_clk(clk), .i_reset(rst), .i_enable(enable), .fifo(ifb),
        .o_ddr_data(ddr_b), .o_tx_active(act_b), .o_underrun(ur_b), .o_underrun_count(cnt_b)
    );

    typedef struct {
        logic [31:0] word;
        logic [31:0] exp_fs1;
        logic [31:0] exp_fs0;
    } vec_t;

    localparam int NV = 8;
    vec_t tab [NV];

    logic [31:0] fifo_q [$];
    logic [31:0] exp_a  [$];
    logic [31:0] exp_b  [$];

    int tests = 0;
    int fails = 0;
    int pulls = 0, pulls_b = 0, urs_a = 0, urs_b = 0, falls = 0, act_cycles = 0;
    int n_a = 0, n_b = 0;
    logic [31:0] acc_a = 32'd0, acc_b = 32'd0;
    logic pull_prev = 1'b0;
    logic act_prev  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic push_word(input logic [31:0] w, input logic [31:0] fa, input logic [31:0] fb);
        fifo_q.push_back(w);
        exp_a.push_back(fa);
        exp_b.push_back(fb);
        fifo_empty = 1'b0;
    endtask

    // One clock: FIFO model, pulse counters and frame scoreboard, sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (pull_prev && fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
        fifo_empty = (fifo_q.size() == 0);
        pull_prev  = ifa.o_fifo_pull;
        if (ifa.o_fifo_pull) begin
            pulls++;
            check("pull_when_nonempty", 32'(fifo_q.size() > 0), 32'd1);
        end
        if (ifb.o_fifo_pull) pulls_b++;
        if (ur_a) urs_a++;
        if (ur_b) urs_b++;
        if (act_prev && !act_a) falls++;
        if (act_a) act_cycles++;
        act_prev = act_a;
        if (act_a) begin
            acc_a = {acc_a[29:0], ddr_a[0], ddr_a[1]};
            n_a++;
            if (n_a == 16) begin
                n_a = 0;
                if (exp_a.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL frame_a: got unexpected frame %h, required none", acc_a);
                end else check("frame_a", acc_a, exp_a.pop_front());
            end
        end
        if (act_b) begin
            acc_b = {acc_b[29:0], ddr_b[0], ddr_b[1]};
            n_b++;
            if (n_b == 16) begin
                n_b = 0;
                if (exp_b.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL frame_b: got unexpected frame %h, required none", acc_b);
                end else check("frame_b", acc_b, exp_b.pop_front());
            end
        end
    endtask

    task automatic wait_pull(input string name);
        for (int i = 0; i < 40 && ifa.o_fifo_pull !== 1'b1; i++) step();
        check(name, 32'(ifa.o_fifo_pull), 32'd1);
    endtask

    task automatic wait_frame_done(input string name);
        for (int i = 0; i < 40 && act_a !== 1'b1; i++) step();
        for (int i = 0; i < 40 && act_a !== 1'b0; i++) step();
        check(name, 32'(act_a), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] sat_exp [5];
        int p0, u0, f0, a0;

        tab[0] = '{32'h0000_0000, 32'h8000_4000, 32'h0000_0000};
        tab[1] = '{32'h3FFF_3FFF, 32'hBFFF_7FFF, 32'h3FFF_3FFF};
        tab[2] = '{32'h0001_0001, 32'h8001_4001, 32'h0001_0001};
        tab[3] = '{32'h1234_5678, 32'h9234_5678, 32'h1234_5678};
        tab[4] = '{32'hFFFF_FFFF, 32'hBFFF_7FFF, 32'hFFFF_FFFF};
        tab[5] = '{32'hC000_C000, 32'h8000_4000, 32'hC000_C000};
        tab[6] = '{32'hA5A5_5A5A, 32'hA5A5_5A5A, 32'hA5A5_5A5A};
        tab[7] = '{32'h5A5A_A5A5, 32'h9A5A_65A5, 32'h5A5A_A5A5};
        sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
        sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;

        rst = 1'b1; enable = 1'b0; fifo_empty = 1'b1; fifo_data = 32'd0;
        step(); step();
        check("reset_ddr", 32'(ddr_a), 32'd0);
        check("reset_active", 32'(act_a), 32'd0);
        check("reset_pull", 32'(ifa.o_fifo_pull), 32'd0);
        check("reset_underrun", 32'(ur_a), 32'd0);
        check("reset_count_a", 32'(cnt_a), 32'd0);
        check("reset_count_b", 32'(cnt_b), 32'd0);
        rst = 1'b0;
        step();

        // Single word, FIFO drained afterwards while enabled -> one underrun.
        enable = 1'b1;
        push_word(tab[0].word, tab[0].exp_fs1, tab[0].exp_fs0);
        wait_pull("single_pull");
        step();
        check("single_pull_one_cycle", 32'(ifa.o_fifo_pull), 32'd0);
        check("single_not_active_yet", 32'(act_a), 32'd0);
        step();
        check("single_active_p2", 32'(act_a), 32'd1);
        check("single_pair0_a", 32'(ddr_a), 32'd1);
        check("single_pair0_b", 32'(ddr_b), 32'd0);
        repeat (8) step();
        check("single_pair8_a", 32'(ddr_a), 32'd2);
        repeat (7) step();
        check("single_last_active", 32'(act_a), 32'd1);
        step();
        check("single_idle_active", 32'(act_a), 32'd0);
        check("single_idle_ddr", 32'(ddr_a), 32'd0);
        check("single_underrun_pulse", 32'(ur_a), 32'd1);
        check("single_count_a", 32'(cnt_a), 32'd1);
        check("single_count_b", 32'(cnt_b), 32'd1);
        step();
        check("single_underrun_one_cycle", 32'(ur_a), 32'd0);
        check("single_total_pulls", 32'(pulls), 32'd1);

        // Back-to-back frames.
        p0 = pulls;
        push_word(tab[1].word, tab[1].exp_fs1, tab[1].exp_fs0);
        push_word(tab[2].word, tab[2].exp_fs1, tab[2].exp_fs0);
        wait_pull("b2b_first_pull");
        repeat (2) step();
        check("b2b_pair0", 32'(ddr_a), 32'd1);
        step();
        check("b2b_pair1", 32'(ddr_a), 32'd3);
        repeat (13) step();
        check("b2b_prefetch_pull_pair14", 32'(ifa.o_fifo_pull), 32'd1);
        step();
        check("b2b_pair15_active", 32'(act_a), 32'd1);
        step();
        check("b2b_gapless_active", 32'(act_a), 32'd1);
        check("b2b_frame2_pair0", 32'(ddr_a), 32'd1);
        for (int i = 0; i < 40 && act_a !== 1'b0; i++) step();
        check("b2b_end_underrun", 32'(ur_a), 32'd1);
        check("b2b_two_pulls", 32'(pulls - p0), 32'd2);
        check("b2b_count_a", 32'(cnt_a), 32'd2);

        // Clean stop: enable dropped mid-frame with a word still queued.
        push_word(tab[3].word, tab[3].exp_fs1, tab[3].exp_fs0);
        push_word(tab[4].word, tab[4].exp_fs1, tab[4].exp_fs0);
        wait_pull("stop_pull");
        repeat (2) step();
        check("fs0_pair0_b", 32'(ddr_b), 32'd0);
        check("fs1_pair0_a", 32'(ddr_a), 32'd1);
        step();
        check("fs0_pair1_b", 32'(ddr_b), 32'd2);
        repeat (4) step();
        enable = 1'b0;
        p0 = pulls; u0 = urs_a;
        for (int i = 0; i < 40 && act_a !== 1'b0; i++) step();
        check("stop_frame_done", 32'(act_a), 32'd0);
        repeat (3) step();
        check("stop_no_prefetch", 32'(pulls - p0), 32'd0);
        check("stop_no_underrun", 32'(urs_a - u0), 32'd0);
        check("stop_count_unchanged", 32'(cnt_a), 32'd2);

        // Reset mid-frame at pair 7, then refetch.
        enable = 1'b1;
        wait_pull("rst_pull");
        repeat (9) step();
        rst = 1'b1;
        step();
        check("rst_ddr", 32'(ddr_a), 32'd0);
        check("rst_active", 32'(act_a), 32'd0);
        check("rst_pull_low", 32'(ifa.o_fifo_pull), 32'd0);
        check("rst_count", 32'(cnt_a), 32'd0);
        void'(exp_a.pop_front());
        void'(exp_b.pop_front());
        n_a = 0; n_b = 0;
        push_word(tab[5].word, tab[5].exp_fs1, tab[5].exp_fs0);
        step();
        rst = 1'b0;
        wait_pull("rst_refetch");
        wait_frame_done("rst_frame_done");
        check("rst_post_count", 32'(cnt_a), 32'd1);

        // Idle with empty FIFO, then underrun saturation on the 2-bit counter.
        rst = 1'b1; step(); rst = 1'b0;
        urs_a = 0; urs_b = 0; p0 = pulls;
        repeat (20) step();
        check("idle_empty_no_pull", 32'(pulls - p0), 32'd0);
        check("idle_empty_no_underrun", 32'(cnt_a), 32'd0);
        for (int i = 0; i < 5; i++) begin
            push_word(tab[i].word, tab[i].exp_fs1, tab[i].exp_fs0);
            wait_pull("sat_pull");
            wait_frame_done("sat_frame_done");
            check("sat_pulse_b", 32'(ur_b), 32'd1);
            check("sat_count_b", 32'(cnt_b), 32'(sat_exp[i]));
        end
        step();
        check("sat_pulses_b", 32'(urs_b), 32'd5);
        check("sat_count_a", 32'(cnt_a), 32'd5);

        // Table stream: all words queued at once, must stream gaplessly.
        p0 = pulls; f0 = falls; a0 = act_cycles;
        for (int i = 0; i < NV; i++) push_word(tab[i].word, tab[i].exp_fs1, tab[i].exp_fs0);
        wait_pull("tab_pull");
        for (int i = 0; i < 400 && !(exp_a.size() == 0 && act_a === 1'b0); i++) step();
        check("tab_pulls", 32'(pulls - p0), 32'(NV));
        check("tab_active_cycles", 32'(act_cycles - a0), 32'(16 * NV));
        check("tab_single_burst", 32'(falls - f0), 32'd1);
        check("tab_exp_a_drained", 32'(exp_a.size()), 32'd0);
        check("tab_exp_b_drained", 32'(exp_b.size()), 32'd0);
        check("pulls_b_match", 32'(pulls_b), 32'(pulls));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
